// File: rtl/fetch_run_control.sv
// Debug run-control FSM for the fetch stage: halt/run/step/CPU-reset sequencing driven by UART debug commands.
// Optional hardware breakpoint compiled in with `define BREAKPOINT_EN.
module fetch_run_control #(
    parameter int PC_WIDTH   = 6,
    parameter int RST_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [PC_WIDTH-1:0] cmd_arg,
    input  logic                nop_stop,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                fetch_enable,
    output logic                fetch_flush,
    output logic                pc_load,
    output logic [PC_WIDTH-1:0] pc_load_value,
    output logic                core_reset,
    output logic                halted,
    output logic [1:0]          halt_cause
);

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_HALT      = 3'd1;
    localparam logic [2:0] OP_RUN       = 3'd2;
    localparam logic [2:0] OP_STEP      = 3'd3;
    localparam logic [2:0] OP_RESET_CPU = 3'd4;
    localparam logic [2:0] OP_SETPC     = 3'd5;
    localparam logic [2:0] OP_SETBP     = 3'd6;
    localparam logic [2:0] OP_CLRBP     = 3'd7;

    localparam logic [1:0] CAUSE_CMD  = 2'd0;
    localparam logic [1:0] CAUSE_NOP  = 2'd1;
    localparam logic [1:0] CAUSE_STEP = 2'd2;
    localparam logic [1:0] CAUSE_BP   = 2'd3;

    localparam int             RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HALTED   = 3'd0,
        S_FLUSH    = 3'd1,
        S_RUNNING  = 3'd2,
        S_STEPPING = 3'd3,
        S_CPURESET = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  flush_cnt_q, flush_cnt_d;
    logic [RC_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic [PC_WIDTH-1:0]   step_cnt_q, step_cnt_d;
    logic                  step_mode_q, step_mode_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  fetch_enable_d, fetch_flush_d, pc_load_d, core_reset_d, halted_d;
    logic [PC_WIDTH-1:0]   pc_load_value_d;
    logic [1:0]            cause_d;
    logic                  accept;
    logic                  bp_hit;

    // Ready is registered from the next state but forced low while reset is held.
    assign cmd_ready = cmd_ready_q && !reset;
    assign accept    = cmd_valid && cmd_ready;

`ifdef BREAKPOINT_EN
    logic [PC_WIDTH-1:0] bp_addr_q, bp_addr_d;
    logic                bp_valid_q, bp_valid_d;
    logic                skip_bp_q;

    // The first enabled cycle after a flush may sit on the breakpoint we just halted at.
    assign bp_hit = bp_valid_q && fetch_enable && !skip_bp_q && (pc == bp_addr_q);

    always_comb begin
        bp_addr_d  = bp_addr_q;
        bp_valid_d = bp_valid_q;
        if (accept && cmd_op == OP_SETBP) begin
            bp_addr_d  = cmd_arg;
            bp_valid_d = 1'b1;
        end else if (accept && cmd_op == OP_CLRBP) begin
            bp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bp_addr_q  <= '0;
            bp_valid_q <= 1'b0;
            skip_bp_q  <= 1'b0;
        end else begin
            bp_addr_q  <= bp_addr_d;
            bp_valid_q <= bp_valid_d;
            skip_bp_q  <= (state_q == S_FLUSH);
        end
    end
`else
    logic [PC_WIDTH-1:0] unused_pc;
    assign unused_pc = pc;
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = 1'b0;
        rst_cnt_d       = '0;
        step_cnt_d      = step_cnt_q;
        step_mode_d     = step_mode_q;
        cause_d         = halt_cause;
        pc_load_d       = 1'b0;
        pc_load_value_d = '0;

        if (fetch_enable && step_cnt_q != '0)
            step_cnt_d = step_cnt_q - PC_WIDTH'(1);

        case (state_q)
            S_HALTED: begin
                if (accept) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_d     = S_FLUSH;
                            step_mode_d = 1'b0;
                        end
                        OP_STEP: begin
                            state_d     = S_FLUSH;
                            step_mode_d = 1'b1;
                            step_cnt_d  = (cmd_arg == '0) ? PC_WIDTH'(1) : cmd_arg;
                        end
                        OP_RESET_CPU: state_d = S_CPURESET;
                        OP_SETPC: begin
                            pc_load_d       = 1'b1;
                            pc_load_value_d = cmd_arg;
                        end
                        default: ;
                    endcase
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q)
                    state_d = step_mode_q ? S_STEPPING : S_RUNNING;
                else
                    flush_cnt_d = 1'b1;
            end
            S_RUNNING, S_STEPPING: begin
                if (accept && cmd_op == OP_RESET_CPU) begin
                    state_d = S_CPURESET;
                end else if (accept && cmd_op == OP_HALT) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_CMD;
                end else if (nop_stop) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_NOP;
                end else if (bp_hit) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_BP;
                end else if (state_q == S_STEPPING && step_cnt_q <= PC_WIDTH'(1)) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_STEP;
                end
            end
            S_CPURESET: begin
                if (rst_cnt_q == RC_LAST) begin
                    state_d    = S_HALTED;
                    cause_d    = CAUSE_CMD;
                    step_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            default: state_d = S_HALTED;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        fetch_enable_d = (state_d == S_RUNNING) || (state_d == S_STEPPING);
        fetch_flush_d  = (state_d == S_FLUSH);
        core_reset_d   = (state_d == S_CPURESET);
        halted_d       = (state_d == S_HALTED);
        cmd_ready_d    = (state_d == S_HALTED) || (state_d == S_RUNNING) || (state_d == S_STEPPING);
        if (state_d == S_CPURESET && rst_cnt_d == RC_LAST) begin
            pc_load_d       = 1'b1;
            pc_load_value_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_HALTED;
            flush_cnt_q   <= 1'b0;
            rst_cnt_q     <= '0;
            step_cnt_q    <= '0;
            step_mode_q   <= 1'b0;
            cmd_ready_q   <= 1'b1;
            fetch_enable  <= 1'b0;
            fetch_flush   <= 1'b0;
            pc_load       <= 1'b0;
            pc_load_value <= '0;
            core_reset    <= 1'b0;
            halted        <= 1'b1;
            halt_cause    <= CAUSE_CMD;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            rst_cnt_q     <= rst_cnt_d;
            step_cnt_q    <= step_cnt_d;
            step_mode_q   <= step_mode_d;
            cmd_ready_q   <= cmd_ready_d;
            fetch_enable  <= fetch_enable_d;
            fetch_flush   <= fetch_flush_d;
            pc_load       <= pc_load_d;
            pc_load_value <= pc_load_value_d;
            core_reset    <= core_reset_d;
            halted        <= halted_d;
            halt_cause    <= cause_d;
        end
    end

endmodule

// File: tb/tb_fetch_run_control.sv
// Directed bench for fetch_run_control: run/step/halt/setpc/cpu-reset sequencing and reset abort.
module tb_fetch_run_control;

    localparam logic [2:0] OP_NOP = 3'd0, OP_HALT = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3;
    localparam logic [2:0] OP_RESET_CPU = 3'd4, OP_SETPC = 3'd5, OP_SETBP = 3'd6, OP_CLRBP = 3'd7;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [5:0] cmd_arg;
    logic       nop_stop;
    logic [5:0] pc;
    logic       fetch_enable, fetch_flush, pc_load, core_reset, halted;
    logic [5:0] pc_load_value;
    logic [1:0] halt_cause;

    int total = 0;
    int bad   = 0;

    fetch_run_control dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .nop_stop(nop_stop), .pc(pc),
        .fetch_enable(fetch_enable), .fetch_flush(fetch_flush), .pc_load(pc_load),
        .pc_load_value(pc_load_value), .core_reset(core_reset), .halted(halted),
        .halt_cause(halt_cause)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [5:0] arg);
        check("cmd_ready_before_send", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = '0;
    endtask

    task automatic start_run();
        send(OP_RUN, 6'd0);
        tick();
        tick();
    endtask

    // Counts flush and fetch-enable cycles from the accept edge until the bound.
    task automatic step_and_count(input logic [5:0] arg, output int fl, output int fe);
        send(OP_STEP, arg);
        fl = fetch_flush ? 1 : 0;
        fe = fetch_enable ? 1 : 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (fetch_flush) fl++;
            if (fetch_enable) fe++;
        end
    endtask

    initial begin
        int fl, fe;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = '0; nop_stop = 1'b0; pc = '0;
        tick();
        cmd_valid = 1'b1; cmd_op = OP_RUN;
        tick();
        cmd_valid = 1'b0; cmd_op = OP_NOP;
        check("rst_halted", halted, 1);
        check("rst_cause", halt_cause, 0);
        check("rst_fetch_enable", fetch_enable, 0);
        check("rst_fetch_flush", fetch_flush, 0);
        check("rst_pc_load", pc_load, 0);
        check("rst_core_reset", core_reset, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        reset = 1'b0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);

        // RUN: two flush cycles then continuous fetch
        send(OP_RUN, 6'd0);
        check("run_flush1", fetch_flush, 1);
        check("run_flush1_fe", fetch_enable, 0);
        check("run_flush1_halted", halted, 0);
        check("run_flush1_ready", cmd_ready, 0);
        tick();
        check("run_flush2", fetch_flush, 1);
        tick();
        check("run_flush_done", fetch_flush, 0);
        check("run_fe", fetch_enable, 1);
        for (int i = 0; i < 5; i++) tick();
        check("run_fe_hold", fetch_enable, 1);
        check("run_not_halted", halted, 0);

        // HALT and nop_stop together: command wins
        nop_stop = 1'b1;
        send(OP_HALT, 6'd0);
        nop_stop = 1'b0;
        check("halt_nop_halted", halted, 1);
        check("halt_nop_cause", halt_cause, 0);
        check("halt_nop_fe", fetch_enable, 0);

        // nop_stop alone
        start_run();
        nop_stop = 1'b1;
        tick();
        nop_stop = 1'b0;
        check("nop_halted", halted, 1);
        check("nop_cause", halt_cause, 1);
        check("nop_fe", fetch_enable, 0);

        // STEP 3 and STEP 0
        step_and_count(6'd3, fl, fe);
        check("step3_flush_cycles", fl, 2);
        check("step3_fe_cycles", fe, 3);
        check("step3_halted", halted, 1);
        check("step3_cause", halt_cause, 2);
        step_and_count(6'd0, fl, fe);
        check("step0_fe_cycles", fe, 1);
        check("step0_cause", halt_cause, 2);
        step_and_count(6'd40, fl, fe);
        check("step40_fe_cycles", fe, 40);

        // nop_stop outranks step completion
        send(OP_STEP, 6'd1);
        tick();
        tick();
        check("step1_fe", fetch_enable, 1);
        nop_stop = 1'b1;
        tick();
        nop_stop = 1'b0;
        check("step_nop_halted", halted, 1);
        check("step_nop_cause", halt_cause, 1);

        // SETPC in HALTED pulses once; ignored while running
        send(OP_SETPC, 6'h2A);
        check("setpc_load", pc_load, 1);
        check("setpc_value", pc_load_value, 6'h2A);
        check("setpc_halted", halted, 1);
        tick();
        check("setpc_one_cycle", pc_load, 0);
        start_run();
        send(OP_SETPC, 6'h2A);
        check("setpc_run_no_load", pc_load, 0);
        check("setpc_run_fe", fetch_enable, 1);
        send(OP_STEP, 6'd2);
        for (int i = 0; i < 4; i++) tick();
        check("step_in_run_ignored", fetch_enable, 1);
        send(OP_HALT, 6'd0);
        check("run_halt_cause", halt_cause, 0);

        // RESET_CPU: four core_reset cycles, pc_load of 0 on the last
        send(OP_RESET_CPU, 6'd0);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("cpurst_core_reset_c%0d", c), core_reset, 1);
            check($sformatf("cpurst_ready_c%0d", c), cmd_ready, 0);
            check($sformatf("cpurst_pc_load_c%0d", c), pc_load, (c == 4) ? 1 : 0);
            if (c < 4) tick();
        end
        check("cpurst_pc_value", pc_load_value, 0);
        tick();
        check("cpurst_done_halted", halted, 1);
        check("cpurst_done_core_reset", core_reset, 0);
        check("cpurst_done_pc_load", pc_load, 0);
        check("cpurst_done_cause", halt_cause, 0);
        check("cpurst_done_ready", cmd_ready, 1);

        // RESET_CPU from RUNNING
        nop_stop = 1'b0;
        start_run();
        send(OP_RESET_CPU, 6'd0);
        check("run_cpurst_core_reset", core_reset, 1);
        check("run_cpurst_fe", fetch_enable, 0);
        for (int i = 0; i < 4; i++) tick();
        check("run_cpurst_halted", halted, 1);

        // Block reset aborts CPU reset with no further pulses
        send(OP_RESET_CPU, 6'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_core_reset", core_reset, 0);
        check("abort_halted", halted, 1);
        fl = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pc_load || core_reset) fl++;
        end
        check("abort_no_pulses", fl, 0);

        // Block reset aborts STEPPING
        send(OP_STEP, 6'd9);
        tick();
        tick();
        check("abort_step_fe", fetch_enable, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_step_fe_off", fetch_enable, 0);
        check("abort_step_halted", halted, 1);
        tick();
        check("abort_step_stays_halted", halted, 1);

`ifdef BREAKPOINT_EN
        send(OP_SETBP, 6'h05);
        pc = 6'h03;
        start_run();
        tick();
        pc = 6'h05;
        tick();
        check("bp_halted", halted, 1);
        check("bp_cause", halt_cause, 3);
        start_run();
        tick();
        check("bp_rerun_no_halt", halted, 0);
        check("bp_rerun_fe", fetch_enable, 1);
        pc = 6'h06;
        tick();
        send(OP_CLRBP, 6'd0);
        pc = 6'h05;
        tick();
        tick();
        check("bp_cleared_running", halted, 0);
        send(OP_HALT, 6'd0);
        check("bp_final_cause", halt_cause, 0);
`else
        send(OP_SETBP, 6'h05);
        pc = 6'h05;
        start_run();
        for (int i = 0; i < 3; i++) tick();
        check("nobp_running", halted, 0);
        check("nobp_fe", fetch_enable, 1);
        send(OP_HALT, 6'd0);
        check("nobp_cause", halt_cause, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
